cpu6_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the cpu6 five-stage core. It sequences the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) by generating per-stage stall (hold) and flush (bubble-insert) controls and the EX-stage operand forwarding selects. It resolves three hazard classes:
- load-use hazards;
- taken branches and jumps resolved in EX, which need a two-cycle redirect because instruction memory is synchronous;
- data-memory wait states.

It sits beside the datapath; its outputs drive the enables and clears of the pipeline register modules.

---
 rtl/cpu6_hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cpu6_hazard_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_hazard_ctrl.sv
// cpu6_hazard_ctrl: stall/flush sequencing and EX operand forwarding for the cpu6 pipeline.
// Optional feature macro: CPU6_HAZARD_PERFCNT_EN builds the stall/redirect counters.
module cpu6_hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs1D,
   input  logic [4:0]  rs2D,
   input  logic [4:0]  rs1E,
   input  logic [4:0]  rs2E,
   input  logic [4:0]  rdE,
   input  logic        regwriteE,
   input  logic        memtoregE,
   input  logic        branch_takenE,
   input  logic        jumpE,
   input  logic [4:0]  rdM,
   input  logic        regwriteM,
   input  logic [4:0]  rdW,
   input  logic        regwriteW,
   input  logic        dmem_reqM,
   input  logic        dmem_readyM,
   output logic        stallF,
   output logic        stallD,
   output logic        stallE,
   output logic        stallM,
   output logic        flushD,
   output logic        flushE,
   output logic        flushW,
   output logic [1:0]  forwardAE,
   output logic [1:0]  forwardBE,
   output logic        redirectE,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   typedef enum logic [1:0] {
      StRun      = 2'b00,
      StRedirect = 2'b01,
      StMemwait  = 2'b10
   } state_e;

   state_e state_q, state_d;

   logic memwait;
   logic take;
   logic lduse;

   assign memwait = dmem_reqM & ~dmem_readyM;
   assign take    = branch_takenE | jumpE;
   assign lduse   = memtoregE & regwriteE & (rdE != 5'd0) &
                    ((rdE == rs1D) | (rdE == rs2D));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: the wait dominates, a taken branch opens the fetch shadow.
   always_comb begin
      state_d = StRun;
      case (state_q)
         StRun, StRedirect, StMemwait: begin
            if (memwait) begin
               state_d = StMemwait;
            end else if (take) begin
               state_d = StRedirect;
            end else begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // Outputs. A finished wait (MEMWAIT without memwait) falls through to the RUN rules.
   always_comb begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushW    = 1'b0;
      redirectE = 1'b0;
      if (!reset) begin
         if (memwait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else if (take) begin
            redirectE = 1'b1;
            flushD    = 1'b1;
            flushE    = 1'b1;
         end else begin
            case (state_q)
               StRedirect: begin
                  // Discard the wrong-path word already in flight from the synchronous fetch.
                  flushD = 1'b1;
               end
               default: begin
                  if (lduse) begin
                     stallF = 1'b1;
                     stallD = 1'b1;
                     flushE = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // Forwarding: MEM result is younger than WB, so it wins; x0 is never forwarded.
   always_comb begin
      forwardAE = 2'b00;
      if (regwriteM && (rdM != 5'd0) && (rdM == rs1E)) begin
         forwardAE = 2'b10;
      end else if (regwriteW && (rdW != 5'd0) && (rdW == rs1E)) begin
         forwardAE = 2'b01;
      end
   end

   always_comb begin
      forwardBE = 2'b00;
      if (regwriteM && (rdM != 5'd0) && (rdM == rs2E)) begin
         forwardBE = 2'b10;
      end else if (regwriteW && (rdW != 5'd0) && (rdW == rs2E)) begin
         forwardBE = 2'b01;
      end
   end

`ifdef CPU6_HAZARD_PERFCNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (stallF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (redirectE) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_events = flush_cnt_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_events = 32'd0;
`endif

`ifndef SYNTHESIS
   a_state_legal: assert property (@(posedge clk) disable iff (reset)
      state_q inside {StRun, StRedirect, StMemwait});
   a_no_redirect_while_stalled: assert property (@(posedge clk) disable iff (reset)
      !(redirectE && stallF));
   a_no_fwd_x0_a: assert property (@(posedge clk) (forwardAE != 2'b00) |-> (rs1E != 5'd0));
   a_no_fwd_x0_b: assert property (@(posedge clk) (forwardBE != 2'b00) |-> (rs2E != 5'd0));
`endif

endmodule

// File: tb/tb_cpu6_hazard_ctrl.sv
// Self-checking bench for cpu6_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_cpu6_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic        regwriteE, memtoregE, branch_takenE, jumpE;
   logic        regwriteM, regwriteW, dmem_reqM, dmem_readyM;
   logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirectE;
   logic [1:0]  forwardAE, forwardBE;
   logic [31:0] stall_cycles, flush_events;

   always #5 clk = ~clk;

   cpu6_hazard_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .rs1D          (rs1D),
      .rs2D          (rs2D),
      .rs1E          (rs1E),
      .rs2E          (rs2E),
      .rdE           (rdE),
      .regwriteE     (regwriteE),
      .memtoregE     (memtoregE),
      .branch_takenE (branch_takenE),
      .jumpE         (jumpE),
      .rdM           (rdM),
      .regwriteM     (regwriteM),
      .rdW           (rdW),
      .regwriteW     (regwriteW),
      .dmem_reqM     (dmem_reqM),
      .dmem_readyM   (dmem_readyM),
      .stallF        (stallF),
      .stallD        (stallD),
      .stallE        (stallE),
      .stallM        (stallM),
      .flushD        (flushD),
      .flushE        (flushE),
      .flushW        (flushW),
      .forwardAE     (forwardAE),
      .forwardBE     (forwardBE),
      .redirectE     (redirectE),
      .stall_cycles  (stall_cycles),
      .flush_events  (flush_events)
   );

   // {stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirectE}
   logic [7:0] ctl;
   assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirectE};

   localparam logic [7:0] CtlIdle   = 8'b0000_0000;
   localparam logic [7:0] CtlWait   = 8'b1111_0010;
   localparam logic [7:0] CtlTake   = 8'b0000_1101;
   localparam logic [7:0] CtlShadow = 8'b0000_1000;
   localparam logic [7:0] CtlLdu    = 8'b1100_0100;

   int checks = 0;
   int errors = 0;

   // Model state: was the previous cycle a redirect, and the two event counts.
   bit          m_redir;
   logic [31:0] m_stall;
   logic [31:0] m_flush;

   function automatic logic [7:0] model_ctl();
      if (reset) return CtlIdle;
      if (dmem_reqM && !dmem_readyM) return CtlWait;
      if (branch_takenE || jumpE) return CtlTake;
      if (m_redir) return CtlShadow;
      if (memtoregE && regwriteE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D)) return CtlLdu;
      return CtlIdle;
   endfunction

   function automatic logic [1:0] model_sel(input logic [4:0] rs);
      if (regwriteM && rdM != 5'd0 && rdM == rs) return 2'b10;
      if (regwriteW && rdW != 5'd0 && rdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_redir = 1'b0;
      m_stall = 32'd0;
      m_flush = 32'd0;
   endtask

   // Call exactly at the rising edge, with inputs still stable from the cycle.
   task automatic model_tick(input logic [7:0] c);
      if (!reset) begin
         m_redir = c[0];
`ifdef CPU6_HAZARD_PERFCNT_EN
         if (c[7]) m_stall = m_stall + 32'd1;
         if (c[0]) m_flush = m_flush + 32'd1;
`endif
      end
   endtask

   task automatic set_idle();
      rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
      rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
      regwriteE = 1'b0; memtoregE = 1'b0; branch_takenE = 1'b0; jumpE = 1'b0;
      regwriteM = 1'b0; regwriteW = 1'b0; dmem_reqM = 1'b0; dmem_readyM = 1'b0;
   endtask

   task automatic end_cycle();
      @(posedge clk);
      model_tick(model_ctl());
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (ctl !== CtlIdle) begin
         errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CtlIdle);
      end
      checks++;
      if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
         errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events);
      end
      // Hazards and forwarding inputs while held in reset.
      dmem_reqM = 1'b1; branch_takenE = 1'b1; rs1E = 5'd7; rdM = 5'd7; regwriteM = 1'b1;
      rs2E = 5'd3; rdW = 5'd3; regwriteW = 1'b1;
      #1;
      checks++;
      if (ctl !== CtlIdle) begin
         errors++; $display("FAIL reset_hold_ctl got=%b exp=%b", ctl, CtlIdle);
      end
      checks++;
      if ({forwardAE, forwardBE} !== 4'b1001) begin
         errors++; $display("FAIL reset_fwd got=%b exp=1001", {forwardAE, forwardBE});
      end
      repeat (2) end_cycle();
      #1;
      checks++;
      if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
         errors++; $display("FAIL reset_hold_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events);
      end
      @(negedge clk);
      set_idle();
      reset = 1'b0;
   endtask

   task automatic test_load_use();
      @(negedge clk);
      set_idle(); memtoregE = 1'b1; regwriteE = 1'b1; rdE = 5'd5; rs1D = 5'd5; #1;
      checks++;
      if (ctl !== CtlLdu) begin
         errors++; $display("FAIL load_use_stall got=%b exp=%b", ctl, CtlLdu);
      end
      end_cycle();
      @(negedge clk);
      memtoregE = 1'b0; regwriteE = 1'b0; rdE = 5'd0; #1;
      checks++;
      if (ctl !== CtlIdle) begin
         errors++; $display("FAIL load_use_release got=%b exp=%b", ctl, CtlIdle);
      end
      checks++;
      if (stall_cycles !== m_stall) begin
         errors++; $display("FAIL load_use_count got=%0d exp=%0d", stall_cycles, m_stall);
      end
      end_cycle();
      // rd = x0 never creates a load-use stall.
      @(negedge clk);
      memtoregE = 1'b1; regwriteE = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0; #1;
      checks++;
      if (ctl !== CtlIdle) begin
         errors++; $display("FAIL load_use_x0 got=%b exp=%b", ctl, CtlIdle);
      end
      end_cycle();
   endtask

   task automatic test_branch();
      logic [7:0] exp_seq [3];
      exp_seq[0] = CtlTake; exp_seq[1] = CtlShadow; exp_seq[2] = CtlIdle;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         set_idle(); branch_takenE = (i == 0); #1;
         checks++;
         if (ctl !== exp_seq[i]) begin
            errors++; $display("FAIL branch_step%0d got=%b exp=%b", i, ctl, exp_seq[i]);
         end
         end_cycle();
      end
      #1;
      checks++;
      if (flush_events !== m_flush) begin
         errors++; $display("FAIL branch_count got=%0d exp=%0d", flush_events, m_flush);
      end
      // A jump behaves the same way.
      @(negedge clk);
      set_idle(); jumpE = 1'b1; #1;
      checks++;
      if (ctl !== CtlTake) begin
         errors++; $display("FAIL jump_take got=%b exp=%b", ctl, CtlTake);
      end
      end_cycle();
   endtask

   task automatic test_memwait();
      logic [31:0] stall_before;
      stall_before = m_stall;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_idle(); dmem_reqM = 1'b1; dmem_readyM = (i == 3); #1;
         checks++;
         if (ctl !== ((i == 3) ? CtlIdle : CtlWait)) begin
            errors++; $display("FAIL memwait_step%0d got=%b exp=%b", i, ctl,
                               (i == 3) ? CtlIdle : CtlWait);
         end
         end_cycle();
      end
      @(negedge clk);
      set_idle(); #1;
      checks++;
      if (stall_cycles !== m_stall) begin
         errors++; $display("FAIL memwait_count got=%0d exp=%0d (before %0d)",
                            stall_cycles, m_stall, stall_before);
      end
   endtask

   task automatic test_memwait_take();
      logic [7:0] exp_seq [5];
      exp_seq[0] = CtlWait; exp_seq[1] = CtlWait; exp_seq[2] = CtlTake;
      exp_seq[3] = CtlShadow; exp_seq[4] = CtlIdle;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         set_idle();
         branch_takenE = (i < 3);
         dmem_reqM     = (i < 3);
         dmem_readyM   = (i == 2);
         // A load-use condition under the wait must not leak through.
         memtoregE = 1'b1; regwriteE = (i < 3); rdE = 5'd9; rs2D = 5'd9;
         #1;
         checks++;
         if (ctl !== exp_seq[i]) begin
            errors++; $display("FAIL memwait_take_step%0d got=%b exp=%b", i, ctl, exp_seq[i]);
         end
         end_cycle();
      end
   endtask

   task automatic test_forwarding();
      @(negedge clk);
      set_idle();
      rs1E = 5'd7; rs2E = 5'd7; rdM = 5'd7; rdW = 5'd7; regwriteM = 1'b1; regwriteW = 1'b1; #1;
      checks++;
      if (forwardAE !== 2'b10) begin
         errors++; $display("FAIL fwd_mem_priority got=%b exp=10", forwardAE);
      end
      rdM = 5'd0; #1;
      checks++;
      if (forwardAE !== 2'b01) begin
         errors++; $display("FAIL fwd_wb got=%b exp=01", forwardAE);
      end
      rs2E = 5'd0; rdW = 5'd0; regwriteM = 1'b1; #1;
      checks++;
      if (forwardBE !== 2'b00) begin
         errors++; $display("FAIL fwd_x0 got=%b exp=00", forwardBE);
      end
      for (int i = 0; i < 40; i++) begin
         rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
         rdM  = 5'($urandom_range(0, 3)); rdW  = 5'($urandom_range(0, 3));
         regwriteM = 1'($urandom); regwriteW = 1'($urandom); #1;
         checks++;
         if ({forwardAE, forwardBE} !== {model_sel(rs1E), model_sel(rs2E)}) begin
            errors++; $display("FAIL fwd_rand%0d got=%b exp=%b", i, {forwardAE, forwardBE},
                               {model_sel(rs1E), model_sel(rs2E)});
         end
      end
      end_cycle();
   endtask

   task automatic test_reset_mid();
      // Reset in the middle of a memory wait.
      @(negedge clk);
      set_idle(); dmem_reqM = 1'b1; #1;
      end_cycle();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (ctl !== CtlIdle) begin
         errors++; $display("FAIL reset_mid_wait_ctl got=%b exp=%b", ctl, CtlIdle);
      end
      checks++;
      if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
         errors++; $display("FAIL reset_mid_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events);
      end
      end_cycle();
      @(negedge clk);
      reset = 1'b0; set_idle(); #1;
      checks++;
      if (ctl !== CtlIdle) begin
         errors++; $display("FAIL reset_mid_wait_resume got=%b exp=%b", ctl, CtlIdle);
      end
      end_cycle();
      // Reset in the middle of the redirect shadow: must resume without the D flush.
      @(negedge clk);
      set_idle(); branch_takenE = 1'b1; #1;
      end_cycle();
      #2;
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0; set_idle(); #1;
      checks++;
      if (ctl !== CtlIdle) begin
         errors++; $display("FAIL reset_mid_redirect_resume got=%b exp=%b", ctl, CtlIdle);
      end
      end_cycle();
   endtask

   task automatic test_random();
      logic [7:0] exp;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         checks++;
         if (stall_cycles !== m_stall || flush_events !== m_flush) begin
            errors++; $display("FAIL rand_counters%0d got=%0d/%0d exp=%0d/%0d", i,
                               stall_cycles, flush_events, m_stall, m_flush);
         end
         rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
         rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
         rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
         rdW  = 5'($urandom_range(0, 3));
         regwriteE = 1'($urandom); memtoregE = 1'($urandom);
         regwriteM = 1'($urandom); regwriteW = 1'($urandom);
         branch_takenE = ($urandom_range(0, 5) == 0);
         jumpE         = ($urandom_range(0, 9) == 0);
         dmem_reqM     = ($urandom_range(0, 2) == 0);
         dmem_readyM   = 1'($urandom);
         #1;
         exp = model_ctl();
         checks++;
         if (ctl !== exp) begin
            errors++; $display("FAIL rand_ctl%0d got=%b exp=%b", i, ctl, exp);
         end
         checks++;
         if ({forwardAE, forwardBE} !== {model_sel(rs1E), model_sel(rs2E)}) begin
            errors++; $display("FAIL rand_fwd%0d got=%b exp=%b", i, {forwardAE, forwardBE},
                               {model_sel(rs1E), model_sel(rs2E)});
         end
         end_cycle();
      end
   endtask

   initial begin
      reset = 1'b1;
      set_idle();
      model_reset();
      test_reset();
      test_load_use();
      test_branch();
      test_memwait();
      test_memwait_take();
      test_forwarding();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
